// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: funct3 access codes, data-memory FSM states, opcodes.
// Latency: none (types and constants only).
// Backpressure: none.
//
// Imported by the data-memory responder and its interface users. The opcode
// constants are shared with the control unit that produces Memread/Memwrite.
package riscv_pkg;

  // Load/store funct3 (instr[14:12]); bit 2 selects zero-extension on loads.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Major opcodes that drive Memread / Memwrite in the control unit.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } mau_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  // Access size from funct3[1:0]; the reserved encodings (x11, 110) land on word.
  function automatic acc_size_e f3_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core <-> data-memory bus: load/store strobes, address, data and stall/done status.
// Latency: none (wiring only).
// Backpressure: slave holds stall high until the one-cycle done pulse.
//
// Signals: mem_read/mem_write/funct3/addr/wdata (core -> memory),
//          rdata/stall/done/misalign (memory -> core).
interface mem_access_unit_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        misalign;

  modport master (
    output mem_read, mem_write, funct3, addr, wdata,
    input  rdata, stall, done, misalign
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata,
    output rdata, stall, done, misalign
  );
endinterface

// File: rtl/dmem_array.sv
// Word-wide data storage with per-byte write enables and a registered read port.
// Latency: read data valid the cycle after en_i; writes land on the same edge.
// Backpressure: none, accepts one strobe per cycle.
//
// Ports: clk_i, en_i (access strobe), we_i[3:0] (byte lanes), idx_i (word
//        index), wdata_i, rdata_o (registered, pre-write contents on a store).
// Contents are never reset.
module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [3:0]            we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory responder: byte/half/word loads and stores for the single-cycle core.
// Latency: done pulses WAIT_CYCLES+2 cycles after the request is sampled in IDLE.
// Backpressure: stall freezes the core from request through ACCESS; 0 in DONE.
//
// Ports: clk, rst (async, active-high), bus (slave modport of mem_access_unit_if).
// Build option MISALIGN_TRAP_EN: when defined, misaligned half/word accesses
// skip the array and finish with misalign=1, rdata=0; when undefined the low
// address bits are aligned down and misalign stays 0.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  localparam int         AW        = DEPTH_LOG2 + 2;
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LAST = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mau_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_wr_q, op_wr_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          trap_q, trap_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          req;
  acc_size_e     size_in;
  acc_size_e     size_q;
  logic [AW-1:0] addr_in;
  logic          trap_in;

  assign req     = bus.mem_read | bus.mem_write;
  assign size_in = f3_size(bus.funct3[1:0]);
  assign size_q  = f3_size(f3_q[1:0]);

  // Address bits above the array depth only alias, so they are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:AW];

`ifdef MISALIGN_TRAP_EN
  assign trap_in = ((size_in == SZ_H) && bus.addr[0]) ||
                   ((size_in == SZ_W) && (bus.addr[1:0] != 2'b00));
  assign addr_in = bus.addr[AW-1:0];
  assign bus.misalign = (state_q == ST_DONE) && trap_q;
`else
  logic [1:0] lo_aligned;

  always_comb begin
    case (size_in)
      SZ_B:    lo_aligned = bus.addr[1:0];
      SZ_H:    lo_aligned = {bus.addr[1], 1'b0};
      default: lo_aligned = 2'b00;
    endcase
  end

  assign trap_in = 1'b0;
  assign addr_in = {bus.addr[AW-1:2], lo_aligned};
  assign bus.misalign = 1'b0;
`endif

  // Next state. Request fields are captured only when leaving IDLE, so input
  // changes during WAIT/ACCESS have no effect. Write wins if both strobes are set.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    trap_d  = trap_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_wr_d = bus.mem_write;
          f3_d    = bus.funct3;
          addr_d  = addr_in;
          wdata_d = bus.wdata;
          trap_d  = trap_in;
          cnt_d   = 4'd0;
          if (HAS_WAIT)     state_d = ST_WAIT;
          else if (trap_in) state_d = ST_DONE;
          else              state_d = ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = trap_q ? ST_DONE : ST_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Store lanes: data is replicated so any enabled lane sees the right bytes.
  logic [3:0]  be;
  logic [31:0] wlane;

  always_comb begin
    case (size_q)
      SZ_B: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        be    = 4'b0011 << {addr_q[1], 1'b0};
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  logic        arr_en;
  logic [3:0]  arr_we;
  logic [31:0] arr_rdata;

  assign arr_en = (state_q == ST_ACCESS);
  assign arr_we = (arr_en && op_wr_q) ? be : 4'b0000;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_dmem (
    .clk_i   (clk),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .idx_i   (addr_q[AW-1:2]),
    .wdata_i (wlane),
    .rdata_o (arr_rdata)
  );

  // Load extraction from the registered array word, valid in DONE.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] load_val;

  assign byte_sel = arr_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = arr_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SZ_B:    load_ext = f3_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_ext = f3_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = arr_rdata;
    endcase
  end

  // Stores and trapped accesses never expose the stale array read register.
  assign load_val = (op_wr_q || trap_q) ? 32'h0 : load_ext;

  // rdata tracks the result in DONE and holds it afterwards.
  assign rdata_d   = (state_q == ST_DONE) ? load_val : rdata_q;
  assign bus.rdata = rdata_d;
  assign bus.done  = (state_q == ST_DONE);
  assign bus.stall = ((state_q == ST_IDLE) && req) ||
                     (state_q == ST_WAIT) || (state_q == ST_ACCESS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      trap_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      trap_q  <= trap_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (DEPTH_LOG2=10, WAIT_CYCLES=1).
// Latency: checks done at WAIT_CYCLES+2 cycles and stall duration per access.
// Backpressure: requests are held until done, then released or chained.
module tb_mem_access_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(
    .DEPTH_LOG2  (10),
    .WAIT_CYCLES (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] r_dat;
  logic        r_mis;
  logic        r_sdone;
  int          r_lat;
  int          r_stl;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
  endtask

  // Called just after a negedge with the request on the bus. Counts cycles and
  // stalled cycles until done, sampling 1ns after each negedge.
  task automatic wait_done();
    bit seen = 1'b0;
    r_lat = 0;
    r_stl = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (bus.done) begin
        seen    = 1'b1;
        r_dat   = bus.rdata;
        r_mis   = bus.misalign;
        r_sdone = bus.stall;
      end else begin
        if (bus.stall) r_stl++;
        @(negedge clk);
        r_lat++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    drive(rd, wr, f3, a, wd);
    wait_done();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a);
    op(1'b1, 1'b0, f3, a, 32'h0);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    op(1'b0, 1'b1, f3, a, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store then load, with latency and stall duration
    st(F3_W, 32'h10, 32'hDEADBEEF);
    chk("sw_latency", r_lat, 32'd3);
    chk("sw_stall_cycles", r_stl, 32'd3);
    chk("sw_rdata_zero", r_dat, 32'h0);
    chk("done_stall_low", 32'(r_sdone), 32'd0);
    ld(F3_W, 32'h10);
    chk("lw_10", r_dat, 32'hDEADBEEF);
    chk("lw_latency", r_lat, 32'd3);
    @(negedge clk);
    #1;
    chk("rdata_hold", bus.rdata, 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads
    st(F3_B, 32'h13, 32'h00000080);
    ld(F3_B, 32'h13);
    chk("lb_13", r_dat, 32'hFFFFFF80);
    ld(F3_BU, 32'h13);
    chk("lbu_13", r_dat, 32'h00000080);
    ld(F3_W, 32'h10);
    chk("lw_10_after_sb", r_dat, 32'h80ADBEEF);

    // Halfword store into the upper half; lower half untouched
    st(F3_W, 32'h14, 32'hCAFEF00D);
    st(F3_H, 32'h16, 32'h00001234);
    ld(F3_HU, 32'h16);
    chk("lhu_16", r_dat, 32'h00001234);
    ld(F3_H, 32'h14);
    chk("lh_14", r_dat, 32'hFFFFF00D);
    ld(3'b111, 32'h14);
    chk("reserved_f3_word", r_dat, 32'h1234F00D);

    // Misaligned accesses
    ld(F3_W, 32'h11);
`ifdef MISALIGN_TRAP_EN
    chk("lw_11_misalign", 32'(r_mis), 32'd1);
    chk("lw_11_rdata", r_dat, 32'h0);
    chk("lw_11_latency", r_lat, 32'd2);
`else
    chk("lw_11_misalign", 32'(r_mis), 32'd0);
    chk("lw_11_rdata", r_dat, 32'h80ADBEEF);
    chk("lw_11_latency", r_lat, 32'd3);
`endif
    ld(F3_H, 32'h13);
`ifdef MISALIGN_TRAP_EN
    chk("lh_13_misalign", 32'(r_mis), 32'd1);
    chk("lh_13_rdata", r_dat, 32'h0);
`else
    chk("lh_13_misalign", 32'(r_mis), 32'd0);
    chk("lh_13_rdata", r_dat, 32'hFFFF80AD);
`endif
    ld(F3_W, 32'h10);
    chk("lw_10_unchanged", r_dat, 32'h80ADBEEF);

    // Reset during WAIT of a store aborts it
    st(F3_W, 32'h20, 32'hA5A5A5A5);
    ld(F3_W, 32'h14);
    chk("lw_14_pre_abort", r_dat, 32'h1234F00D);
    @(negedge clk);
    drive(1'b0, 1'b1, F3_W, 32'h20, 32'h55555555);
    #1;
    chk("idle_req_stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    #1;
    chk("wait_stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    #1;
    chk("abort_rdata", bus.rdata, 32'h0);
    chk("abort_stall", 32'(bus.stall), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ld(F3_W, 32'h20);
    chk("lw_20_after_abort", r_dat, 32'hA5A5A5A5);
    chk("lw_20_latency", r_lat, 32'd3);

    // Both strobes high: the store wins
    op(1'b1, 1'b1, F3_W, 32'h24, 32'h0BADF00D);
    chk("both_strobes_rdata", r_dat, 32'h0);
    ld(F3_W, 32'h24);
    chk("lw_24", r_dat, 32'h0BADF00D);

    // Back-to-back requests; 0x1000 aliases word 0
    st(F3_W, 32'h0, 32'h01020304);
    @(negedge clk);
    drive(1'b1, 1'b0, F3_W, 32'h24, 32'h0);
    wait_done();
    chk("b2b_first", r_dat, 32'h0BADF00D);
    drive(1'b1, 1'b0, F3_W, 32'h1000, 32'h0);
    #1;
    chk("done_stall_with_req", 32'(bus.stall), 32'd0);
    @(negedge clk);
    wait_done();
    chk("b2b_latency", r_lat, 32'd3);
    chk("alias_1000", r_dat, 32'h01020304);
    bus.mem_read = 1'b0;
    st(F3_W, 32'h1004, 32'h77777777);
    ld(F3_W, 32'h4);
    chk("alias_store_1004", r_dat, 32'h77777777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
